// File: rtl/dpu_sram_ctrl.sv
// Host-command / SRAM controller that also sequences read-modify-write ops on the dpu.
// Host reads and writes go straight to SRAM; dpu ops run read, load, wait, write-back.
module dpu_sram_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              op_done,
    output logic              busy,
    output logic              dpu_load_cmd,
    output logic              requst_valid,
    output logic [7:0]        nxt_cmd,
    output logic [DATA_W-1:0] dpu_rdata,
    input  logic [DATA_W-1:0] dpu_wdata,
    input  logic [ADDR_W-1:0] dpu_addr,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int unsigned CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [3:0] {
        IDLE, DISP, DRD, DWAIT, DLOAD, DCAL, DWB, HRD, HWAIT, HWR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         cmd_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [CNT_W-1:0]   cnt;
    logic               accept;

    assign cmd_ready = (state == IDLE) && !rsp_valid;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state != IDLE);
    assign dpu_rdata = rdata_q;

    // State, latched command, read-latency counter and host response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_q   <= cmd;
                wdata_q <= cmd_wdata;
            end
            if (state == DRD || state == HRD) begin
                cnt <= CNT_W'(RD_LAT - 1);
            end else if ((state == DWAIT || state == HWAIT) && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (state == DWAIT && cnt == '0) begin
                rdata_q <= sram_rdata;
            end
            if (state == HWAIT && cnt == '0) begin
                rsp_valid <= 1'b1;
                rsp_data  <= sram_rdata;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Next state and per-state strobes to SRAM and dpu
    always_comb begin
        state_nxt    = state;
        dpu_load_cmd = 1'b0;
        nxt_cmd      = '0;
        requst_valid = 1'b0;
        sram_en      = 1'b0;
        sram_we      = 1'b0;
        sram_addr    = '0;
        sram_wdata   = '0;
        op_done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd[7])      state_nxt = DISP;
                    else if (cmd[6]) state_nxt = HWR;
                    else             state_nxt = HRD;
                end
            end
            DISP: begin
                dpu_load_cmd = 1'b1;
                nxt_cmd      = cmd_q;
                state_nxt    = DRD;
            end
            DRD: begin
                sram_en   = 1'b1;
                sram_addr = dpu_addr;
                state_nxt = DWAIT;
            end
            DWAIT: begin
                if (cnt == '0) state_nxt = DLOAD;
            end
            DLOAD: begin
                requst_valid = 1'b1;
                state_nxt    = DCAL;
            end
            DCAL: begin
                state_nxt = DWB;
            end
            DWB: begin
                sram_en      = 1'b1;
                sram_we      = 1'b1;
                sram_addr    = dpu_addr;
                sram_wdata   = dpu_wdata;
                requst_valid = 1'b1;
                op_done      = 1'b1;
                state_nxt    = IDLE;
            end
            HRD: begin
                sram_en   = 1'b1;
                sram_addr = ADDR_W'(cmd_q[4:0]);
                state_nxt = HWAIT;
            end
            HWAIT: begin
                if (cnt == '0) state_nxt = IDLE;
            end
            HWR: begin
                sram_en    = 1'b1;
                sram_we    = 1'b1;
                sram_addr  = ADDR_W'(cmd_q[4:0]);
                sram_wdata = wdata_q;
                op_done    = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dpu_sram_ctrl.sv
// Bench for dpu_sram_ctrl: two instances (RD_LAT 1 and 3) with SRAM and dpu stand-ins,
// checked against a word-array memory model and the dpu arithmetic rules.
module tb_dpu_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [7:0]  cmd [2];
    logic [31:0] cmd_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_data [2];
    logic        op_done [2];
    logic        busy [2];
    logic        dpu_load_cmd [2];
    logic        requst_valid [2];
    logic [7:0]  nxt_cmd [2];
    logic [31:0] dpu_rdata [2];
    logic [31:0] dpu_wdata [2];
    logic [4:0]  dpu_addr [2];
    logic        sram_en [2];
    logic        sram_we [2];
    logic [4:0]  sram_addr [2];
    logic [31:0] sram_wdata [2];
    logic [31:0] sram_rdata [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dpu_sram_ctrl #(.ADDR_W(5), .DATA_W(32), .RD_LAT((g == 0) ? 1 : 3)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd(cmd[g]), .cmd_wdata(cmd_wdata[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_data(rsp_data[g]),
            .op_done(op_done[g]), .busy(busy[g]),
            .dpu_load_cmd(dpu_load_cmd[g]), .requst_valid(requst_valid[g]), .nxt_cmd(nxt_cmd[g]),
            .dpu_rdata(dpu_rdata[g]), .dpu_wdata(dpu_wdata[g]), .dpu_addr(dpu_addr[g]),
            .sram_en(sram_en[g]), .sram_we(sram_we[g]), .sram_addr(sram_addr[g]),
            .sram_wdata(sram_wdata[g]), .sram_rdata(sram_rdata[g])
        );
    end

    // SRAM stand-in: data appears RD_LAT cycles after the read strobe, junk otherwise
    logic [31:0] mem [2][32];
    logic [31:0] rpipe [2][3];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sram_en[k] && sram_we[k]) mem[k][sram_addr[k]] <= sram_wdata[k];
            rpipe[k][0] <= (sram_en[k] && !sram_we[k]) ? mem[k][sram_addr[k]] : 32'hDEAD_BEEF;
            rpipe[k][1] <= rpipe[k][0];
            rpipe[k][2] <= rpipe[k][1];
        end
    end
    assign sram_rdata[0] = rpipe[0][0];
    assign sram_rdata[1] = rpipe[1][2];

    function automatic logic [31:0] dpu_ref(input logic [1:0] m, input logic [31:0] v);
        case (m)
            2'd0:    return v + 32'd1;
            2'd1:    return v - 32'd1;
            2'd2:    return v << 1;
            default: return v >> 1;
        endcase
    endfunction

    // dpu stand-in: load latches cmd, first strobe takes operand, second releases
    logic [7:0]  dcmd [2];
    logic [31:0] dres [2];
    logic        dph [2];
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                dcmd[k] <= '0;
                dres[k] <= '0;
                dph[k]  <= 1'b0;
            end else begin
                if (dpu_load_cmd[k]) begin
                    dcmd[k] <= nxt_cmd[k];
                    dph[k]  <= 1'b0;
                end
                if (requst_valid[k]) begin
                    if (!dph[k]) begin
                        dres[k] <= dpu_ref(dcmd[k][6:5], dpu_rdata[k]);
                        dph[k]  <= 1'b1;
                    end else begin
                        dph[k] <= 1'b0;
                    end
                end
            end
        end
    end
    assign dpu_addr[0]  = dcmd[0][4:0];
    assign dpu_addr[1]  = dcmd[1][4:0];
    assign dpu_wdata[0] = dres[0];
    assign dpu_wdata[1] = dres[1];

    logic [31:0] ref_mem [2][32];

    int          t_load, t_rv1, t_rv2, t_wr, t_done, t_rsp, t_ready, n_wr, n_rd;
    logic [7:0]  nxt_seen;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, rsp_seen;

    // Issue one command (accept = cycle 0) and log event cycles until cmd_ready returns
    task automatic do_op(input int k, input logic [7:0] c, input logic [31:0] wd);
        t_load = -1; t_rv1 = -1; t_rv2 = -1; t_wr = -1; t_done = -1; t_rsp = -1; t_ready = -1;
        n_wr = 0; n_rd = 0;
        @(negedge clk);
        cmd_valid[k] = 1'b1;
        cmd[k]       = c;
        cmd_wdata[k] = wd;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 1) begin
                cmd_valid[k] = 1'b0;
                cmd[k]       = 8'($urandom);
                cmd_wdata[k] = $urandom;
            end
            if (dpu_load_cmd[k] && t_load < 0) begin
                t_load   = n;
                nxt_seen = nxt_cmd[k];
            end
            if (requst_valid[k]) begin
                if (t_rv1 < 0) t_rv1 = n;
                else           t_rv2 = n;
            end
            if (sram_en[k]) begin
                if (sram_we[k]) begin
                    n_wr++;
                    t_wr    = n;
                    wr_addr = sram_addr[k];
                    wr_data = sram_wdata[k];
                end else begin
                    n_rd++;
                end
            end
            if (op_done[k]) t_done = n;
            if (rsp_valid[k] && t_rsp < 0) begin
                t_rsp    = n;
                rsp_seen = rsp_data[k];
            end
            if (cmd_ready[k]) begin
                t_ready = n;
                break;
            end
        end
    endtask

    task automatic host_write(input int k, input logic [4:0] a, input logic [31:0] d);
        do_op(k, {3'b010, a}, d);
        ref_mem[k][a] = d;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cmd_valid[k] = 1'b0; cmd[k] = '0; cmd_wdata[k] = '0; rsp_ready[k] = 1'b1;
        end
        #12;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({cmd_ready[k], busy[k], rsp_valid[k], op_done[k], sram_en[k], sram_we[k],
                 requst_valid[k], dpu_load_cmd[k]} !== 8'b1000_0000) begin
                errors++;
                $display("FAIL reset_ctrl[%0d]: got %b expected 10000000", k,
                         {cmd_ready[k], busy[k], rsp_valid[k], op_done[k], sram_en[k], sram_we[k],
                          requst_valid[k], dpu_load_cmd[k]});
            end
            checks++;
            if ({rsp_data[k], dpu_rdata[k], nxt_cmd[k], sram_addr[k], sram_wdata[k]} !== '0) begin
                errors++;
                $display("FAIL reset_data[%0d]: rsp_data %h dpu_rdata %h nxt_cmd %h addr %h wdata %h, expected all 0",
                         k, rsp_data[k], dpu_rdata[k], nxt_cmd[k], sram_addr[k], sram_wdata[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_host_write_read;
        do_op(0, 8'h45, 32'h0000_0010);
        ref_mem[0][5] = 32'h10;
        checks++;
        if ({t_wr, t_done, t_ready, n_wr} !== {32'd1, 32'd1, 32'd2, 32'd1}) begin
            errors++;
            $display("FAIL hwr_timing: wr %0d done %0d ready %0d writes %0d, expected 1 1 2 1", t_wr, t_done, t_ready, n_wr);
        end
        checks++;
        if ({wr_addr, wr_data} !== {5'd5, 32'h10}) begin
            errors++;
            $display("FAIL hwr_data: addr %0d data %h, expected 5 00000010", wr_addr, wr_data);
        end
        do_op(0, 8'h05, 32'h0);
        checks++;
        if (rsp_seen !== 32'h10 || t_rsp !== 3) begin
            errors++;
            $display("FAIL hrd_rsp: data %h at cycle %0d, expected 00000010 at 3", rsp_seen, t_rsp);
        end
        checks++;
        if (t_ready !== 4 || n_wr !== 0 || n_rd !== 1) begin
            errors++;
            $display("FAIL hrd_ready: ready %0d writes %0d reads %0d, expected 4 0 1", t_ready, n_wr, n_rd);
        end
    endtask

    task automatic test_fill;
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 32; a++)
                host_write(k, 5'(a), $urandom);
        host_write(0, 5'd5, 32'h10);
    endtask

    task automatic test_dpu_plus;
        logic [31:0] exp;
        exp = ref_mem[0][5] + 32'd1;
        do_op(0, 8'h85, $urandom);
        ref_mem[0][5] = exp;
        checks++;
        if (t_load !== 1 || nxt_seen !== 8'h85) begin
            errors++;
            $display("FAIL dpu_load: cycle %0d cmd %h, expected 1 85", t_load, nxt_seen);
        end
        checks++;
        if ({t_rv1, t_rv2} !== {32'd4, 32'd6}) begin
            errors++;
            $display("FAIL dpu_requst: cycles %0d %0d, expected 4 6", t_rv1, t_rv2);
        end
        checks++;
        if ({t_wr, t_done, t_ready, n_wr, n_rd} !== {32'd6, 32'd6, 32'd7, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL dpu_timing: wr %0d done %0d ready %0d writes %0d reads %0d, expected 6 6 7 1 1",
                     t_wr, t_done, t_ready, n_wr, n_rd);
        end
        checks++;
        if ({wr_addr, wr_data} !== {5'd5, 32'h11}) begin
            errors++;
            $display("FAIL dpu_plus_wr: addr %0d data %h, expected 5 00000011", wr_addr, wr_data);
        end
        do_op(0, 8'h05, 32'h0);
        checks++;
        if (rsp_seen !== exp) begin
            errors++;
            $display("FAIL dpu_plus_readback: got %h expected %h", rsp_seen, exp);
        end
    endtask

    task automatic test_dpu_modes;
        logic [7:0]  ops [5];
        logic [31:0] init [5];
        logic [31:0] want [5];
        ops  = '{8'hA2, 8'hC2, 8'hE2, 8'h9F, 8'hA0};
        init = '{32'h8, 32'h8, 32'h8, 32'hFFFF_FFFF, 32'h0};
        want = '{32'h7, 32'h10, 32'h4, 32'h0, 32'hFFFF_FFFF};
        for (int i = 0; i < 5; i++) begin
            host_write(0, ops[i][4:0], init[i]);
            do_op(0, ops[i], $urandom);
            ref_mem[0][ops[i][4:0]] = want[i];
            checks++;
            if ({wr_addr, wr_data, t_done} !== {ops[i][4:0], want[i], 32'd6}) begin
                errors++;
                $display("FAIL dpu_mode_%h: addr %0d data %h done %0d, expected %0d %h 6",
                         ops[i], wr_addr, wr_data, t_done, ops[i][4:0], want[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp, pend;
        int          seen;
        exp  = ref_mem[0][5];
        pend = $urandom;
        seen = -1;
        rsp_ready[0] = 1'b0;
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd[0]       = 8'h05;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) cmd_valid[0] = 1'b0;
            if (rsp_valid[0]) begin
                seen = n;
                break;
            end
        end
        checks++;
        if (seen !== 3 || rsp_data[0] !== exp) begin
            errors++;
            $display("FAIL bp_first_rsp: cycle %0d data %h, expected 3 %h", seen, rsp_data[0], exp);
        end
        cmd_valid[0] = 1'b1;
        cmd[0]       = 8'h4C;
        cmd_wdata[0] = pend;
        for (int n = 0; n < 5; n++) begin
            if (n > 0) @(negedge clk);
            checks++;
            if ({rsp_valid[0], cmd_ready[0], sram_en[0]} !== 3'b100 || rsp_data[0] !== exp) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid/ready/en %b data %h, expected 100 %h", n,
                         {rsp_valid[0], cmd_ready[0], sram_en[0]}, rsp_data[0], exp);
            end
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        checks++;
        if ({rsp_valid[0], cmd_ready[0]} !== 2'b01) begin
            errors++;
            $display("FAIL bp_release: valid/ready %b expected 01", {rsp_valid[0], cmd_ready[0]});
        end
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        checks++;
        if ({sram_en[0], sram_we[0], sram_addr[0], sram_wdata[0]} !== {2'b11, 5'd12, pend}) begin
            errors++;
            $display("FAIL bp_pending_wr: en/we %b addr %0d data %h, expected 11 12 %h",
                     {sram_en[0], sram_we[0]}, sram_addr[0], sram_wdata[0], pend);
        end
        ref_mem[0][12] = pend;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        host_write(0, 5'd9, 32'h1234_5678);
        @(negedge clk);
        cmd_valid[0] = 1'b1;
        cmd[0]       = 8'hC9;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            cmd_valid[0] = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy[0], rsp_valid[0], op_done[0], sram_en[0], requst_valid[0], dpu_load_cmd[0]} !== 6'b0 ||
            {dpu_rdata[0], nxt_cmd[0], sram_wdata[0]} !== '0) begin
            errors++;
            $display("FAIL midop_reset_outputs: busy %b en %b rv %b rdata %h nxt %h, expected all 0",
                     busy[0], sram_en[0], requst_valid[0], dpu_rdata[0], nxt_cmd[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready[0], busy[0], sram_en[0]} !== 3'b100) begin
            errors++;
            $display("FAIL midop_after: ready/busy/en %b expected 100", {cmd_ready[0], busy[0], sram_en[0]});
        end
        checks++;
        if (mem[0][9] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL midop_sram_kept: got %h expected 12345678", mem[0][9]);
        end
    endtask

    task automatic test_rd_lat3;
        host_write(1, 5'd7, 32'h0000_00FF);
        do_op(1, 8'h87, $urandom);
        ref_mem[1][7] = 32'h100;
        checks++;
        if ({t_rv1, t_rv2, t_wr, t_done, t_ready} !== {32'd6, 32'd8, 32'd8, 32'd8, 32'd9}) begin
            errors++;
            $display("FAIL lat3_dpu_timing: rv %0d %0d wr %0d done %0d ready %0d, expected 6 8 8 8 9",
                     t_rv1, t_rv2, t_wr, t_done, t_ready);
        end
        checks++;
        if ({wr_addr, wr_data} !== {5'd7, 32'h100}) begin
            errors++;
            $display("FAIL lat3_dpu_wr: addr %0d data %h, expected 7 00000100", wr_addr, wr_data);
        end
        do_op(1, 8'h07, 32'h0);
        checks++;
        if (rsp_seen !== 32'h100 || t_rsp !== 5) begin
            errors++;
            $display("FAIL lat3_rsp: data %h cycle %0d, expected 00000100 at 5", rsp_seen, t_rsp);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            int          k, op;
            logic [4:0]  a;
            logic [1:0]  m;
            logic [31:0] d, exp;
            k  = int'($urandom_range(1, 0));
            op = int'($urandom_range(2, 0));
            a  = 5'($urandom);
            m  = 2'($urandom);
            d  = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFFF : $urandom;
            if (op == 0) begin
                do_op(k, {2'b01, 1'($urandom), a}, d);
                ref_mem[k][a] = d;
                checks++;
                if ({n_wr, wr_addr, wr_data} !== {32'd1, a, d}) begin
                    errors++;
                    $display("FAIL rnd_write[%0d]: writes %0d addr %0d data %h, expected 1 %0d %h",
                             i, n_wr, wr_addr, wr_data, a, d);
                end
            end else if (op == 1) begin
                do_op(k, {2'b00, 1'($urandom), a}, d);
                checks++;
                if (rsp_seen !== ref_mem[k][a] || t_rsp !== ((k == 0) ? 3 : 5) || n_wr !== 0) begin
                    errors++;
                    $display("FAIL rnd_read[%0d]: data %h cycle %0d writes %0d, expected %h %0d 0",
                             i, rsp_seen, t_rsp, n_wr, ref_mem[k][a], (k == 0) ? 3 : 5);
                end
            end else begin
                exp = dpu_ref(m, ref_mem[k][a]);
                do_op(k, {1'b1, m, a}, d);
                ref_mem[k][a] = exp;
                checks++;
                if ({n_wr, wr_addr, wr_data, t_done} !== {32'd1, a, exp, (k == 0) ? 32'd6 : 32'd8}) begin
                    errors++;
                    $display("FAIL rnd_dpu[%0d]: writes %0d addr %0d data %h done %0d, expected 1 %0d %h %0d",
                             i, n_wr, wr_addr, wr_data, t_done, a, exp, (k == 0) ? 6 : 8);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_host_write_read;
        test_fill;
        test_dpu_plus;
        test_dpu_modes;
        test_backpressure;
        test_reset_mid_op;
        test_rd_lat3;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
